// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the integer ALU
module alu_rs #(
  parameter int RS_SIZE     = 16,
  parameter int ROB_POS_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  output logic                   rs_full,
  input  logic                   disp_en,
  input  logic [6:0]             disp_opcode,
  input  logic [2:0]             disp_func3,
  input  logic                   disp_func1,
  input  logic                   disp_rs1_rdy,
  input  logic [31:0]            disp_rs1_val,
  input  logic [ROB_POS_WID-1:0] disp_rs1_tag,
  input  logic                   disp_rs2_rdy,
  input  logic [31:0]            disp_rs2_val,
  input  logic [ROB_POS_WID-1:0] disp_rs2_tag,
  input  logic [31:0]            disp_imm,
  input  logic [31:0]            disp_pc,
  input  logic [ROB_POS_WID-1:0] disp_rob_pos,
  input  logic                   alu_res_en,
  input  logic [ROB_POS_WID-1:0] alu_res_rob_pos,
  input  logic [31:0]            alu_res_val,
  input  logic                   lsb_res_en,
  input  logic [ROB_POS_WID-1:0] lsb_res_rob_pos,
  input  logic [31:0]            lsb_res_val,
  output logic                   alu_en,
  output logic [6:0]             alu_opcode,
  output logic [2:0]             alu_func3,
  output logic                   alu_func1,
  output logic [31:0]            alu_val1,
  output logic [31:0]            alu_val2,
  output logic [31:0]            alu_imm,
  output logic [31:0]            alu_pc,
  output logic [ROB_POS_WID-1:0] alu_rob_pos
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]     busy;
  logic [RS_SIZE-1:0]     q1_valid;
  logic [RS_SIZE-1:0]     q2_valid;
  logic [RS_SIZE-1:0]     func1_q;
  logic [ROB_POS_WID-1:0] q1_tag  [RS_SIZE];
  logic [ROB_POS_WID-1:0] q2_tag  [RS_SIZE];
  logic [31:0]            v1      [RS_SIZE];
  logic [31:0]            v2      [RS_SIZE];
  logic [6:0]             opcode_q[RS_SIZE];
  logic [2:0]             func3_q [RS_SIZE];
  logic [31:0]            imm_q   [RS_SIZE];
  logic [31:0]            pc_q    [RS_SIZE];
  logic [ROB_POS_WID-1:0] rob_q   [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               d1_wait;
  logic               d2_wait;
  logic [31:0]        d1_val;
  logic [31:0]        d2_val;

  assign ready   = busy & ~q1_valid & ~q2_valid;
  assign rs_full = &busy;

  // Lowest-index free slot for dispatch and lowest-index ready slot for issue, both on pre-edge state
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Capture a same-cycle broadcast for dispatched operands; ALU result beats LSB on a tag tie
  always_comb begin
    d1_wait = !disp_rs1_rdy;
    d1_val  = disp_rs1_val;
    d2_wait = !disp_rs2_rdy;
    d2_val  = disp_rs2_val;
    if (!disp_rs1_rdy) begin
      if (alu_res_en && alu_res_rob_pos == disp_rs1_tag) begin
        d1_wait = 1'b0;
        d1_val  = alu_res_val;
      end else if (lsb_res_en && lsb_res_rob_pos == disp_rs1_tag) begin
        d1_wait = 1'b0;
        d1_val  = lsb_res_val;
      end
    end
    if (!disp_rs2_rdy) begin
      if (alu_res_en && alu_res_rob_pos == disp_rs2_tag) begin
        d2_wait = 1'b0;
        d2_val  = alu_res_val;
      end else if (lsb_res_en && lsb_res_rob_pos == disp_rs2_tag) begin
        d2_wait = 1'b0;
        d2_val  = lsb_res_val;
      end
    end
  end

  // Entry state, wakeup, issue and dispatch; rollback squashes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      q1_valid    <= '0;
      q2_valid    <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_func3   <= '0;
      alu_func1   <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy   <= '0;
        alu_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && q1_valid[i]) begin
            if (alu_res_en && alu_res_rob_pos == q1_tag[i]) begin
              v1[i]       <= alu_res_val;
              q1_valid[i] <= 1'b0;
            end else if (lsb_res_en && lsb_res_rob_pos == q1_tag[i]) begin
              v1[i]       <= lsb_res_val;
              q1_valid[i] <= 1'b0;
            end
          end
          if (busy[i] && q2_valid[i]) begin
            if (alu_res_en && alu_res_rob_pos == q2_tag[i]) begin
              v2[i]       <= alu_res_val;
              q2_valid[i] <= 1'b0;
            end else if (lsb_res_en && lsb_res_rob_pos == q2_tag[i]) begin
              v2[i]       <= lsb_res_val;
              q2_valid[i] <= 1'b0;
            end
          end
        end
        if (sel_found) begin
          alu_en         <= 1'b1;
          alu_opcode     <= opcode_q[sel_idx];
          alu_func3      <= func3_q[sel_idx];
          alu_func1      <= func1_q[sel_idx];
          alu_val1       <= v1[sel_idx];
          alu_val2       <= v2[sel_idx];
          alu_imm        <= imm_q[sel_idx];
          alu_pc         <= pc_q[sel_idx];
          alu_rob_pos    <= rob_q[sel_idx];
          busy[sel_idx]  <= 1'b0;
        end else begin
          alu_en <= 1'b0;
        end
        if (disp_en && free_found) begin
          busy[free_idx]     <= 1'b1;
          q1_valid[free_idx] <= d1_wait;
          q1_tag[free_idx]   <= disp_rs1_tag;
          v1[free_idx]       <= d1_val;
          q2_valid[free_idx] <= d2_wait;
          q2_tag[free_idx]   <= disp_rs2_tag;
          v2[free_idx]       <= d2_val;
          opcode_q[free_idx] <= disp_opcode;
          func3_q[free_idx]  <= disp_func3;
          func1_q[free_idx]  <= disp_func1;
          imm_q[free_idx]    <= disp_imm;
          pc_q[free_idx]     <= disp_pc;
          rob_q[free_idx]    <= disp_rob_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for alu_rs
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        rs_full;
  logic        disp_en;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_func3;
  logic        disp_func1;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm, disp_pc;
  logic [3:0]  disp_rs1_tag, disp_rs2_tag, disp_rob_pos;
  logic        alu_res_en, lsb_res_en;
  logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
  logic [31:0] alu_res_val, lsb_res_val;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic        alu_func1;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int checks = 0;
  int errors = 0;

  alu_rs #(.RS_SIZE(16), .ROB_POS_WID(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_full(rs_full),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func1(disp_func1),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_pos(disp_rob_pos),
    .alu_res_en(alu_res_en), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
    .lsb_res_en(lsb_res_en), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func1(alu_func1),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    disp_en = 1'b0; disp_opcode = '0; disp_func3 = '0; disp_func1 = 1'b0;
    disp_rs1_rdy = 1'b1; disp_rs1_val = '0; disp_rs1_tag = '0;
    disp_rs2_rdy = 1'b1; disp_rs2_val = '0; disp_rs2_tag = '0;
    disp_imm = '0; disp_pc = '0; disp_rob_pos = '0;
    alu_res_en = 1'b0; alu_res_rob_pos = '0; alu_res_val = '0;
    lsb_res_en = 1'b0; lsb_res_rob_pos = '0; lsb_res_val = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic disp(input logic [6:0] op, input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    disp_en = 1'b1; disp_opcode = op;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
    disp_imm = imm; disp_pc = pc; disp_rob_pos = rob;
  endtask

  // Directed vectors: bsrc/wsrc 0=none 1=alu 2=lsb 3=both (alu carries val, lsb carries ~val)
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f1;
    logic r1; logic [31:0] v1; logic [3:0] t1;
    logic r2; logic [31:0] v2; logic [3:0] t2;
    logic [31:0] imm; logic [31:0] pc; logic [3:0] rob;
    int bsrc; logic [3:0] btag; logic [31:0] bval;
    int wsrc; int wcyc; logic [3:0] wtag; logic [31:0] wval;
    logic [31:0] e1; logic [31:0] e2; int lat;
  } vec_t;

  vec_t vecs[8];

  task automatic bcast(input int src, input logic [3:0] tag, input logic [31:0] val);
    alu_res_en = (src == 1 || src == 3); alu_res_rob_pos = tag; alu_res_val = val;
    lsb_res_en = (src == 2 || src == 3); lsb_res_rob_pos = tag;
    lsb_res_val = (src == 3) ? ~val : val;
  endtask

  // Reference model: a bag of entries, each either waiting on tags or holding values
  typedef struct {
    bit busy; bit w1; logic [3:0] t1; logic [31:0] v1;
    bit w2; logic [3:0] t2; logic [31:0] v2;
    logic [6:0] op; logic [2:0] f3; logic f1;
    logic [31:0] imm; logic [31:0] pc; logic [3:0] rob;
  } ment_t;

  ment_t m[16];
  ment_t eo;
  logic  exp_en;

  function automatic bit hit_alu(input logic [3:0] t);
    return alu_res_en && alu_res_rob_pos == t;
  endfunction

  function automatic bit hit_lsb(input logic [3:0] t);
    return lsb_res_en && lsb_res_rob_pos == t;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int pick, slot;
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      exp_en = 0;
      eo = '{default: '0};
      return;
    end
    if (!rdy) return;
    if (rollback) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      exp_en = 0;
      return;
    end
    pick = -1; slot = -1;
    for (int i = 15; i >= 0; i--) begin
      if (m[i].busy && !m[i].w1 && !m[i].w2) pick = i;
      if (!m[i].busy) slot = i;
    end
    exp_en = (pick >= 0);
    if (pick >= 0) begin
      eo = m[pick];
      m[pick].busy = 0;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy && m[i].w1) begin
        if (hit_alu(m[i].t1)) begin m[i].w1 = 0; m[i].v1 = alu_res_val; end
        else if (hit_lsb(m[i].t1)) begin m[i].w1 = 0; m[i].v1 = lsb_res_val; end
      end
      if (m[i].busy && m[i].w2) begin
        if (hit_alu(m[i].t2)) begin m[i].w2 = 0; m[i].v2 = alu_res_val; end
        else if (hit_lsb(m[i].t2)) begin m[i].w2 = 0; m[i].v2 = lsb_res_val; end
      end
    end
    if (disp_en && slot >= 0) begin
      ment_t n;
      n.busy = 1; n.op = disp_opcode; n.f3 = disp_func3; n.f1 = disp_func1;
      n.imm = disp_imm; n.pc = disp_pc; n.rob = disp_rob_pos;
      n.t1 = disp_rs1_tag; n.t2 = disp_rs2_tag;
      n.w1 = !disp_rs1_rdy; n.v1 = disp_rs1_val;
      n.w2 = !disp_rs2_rdy; n.v2 = disp_rs2_val;
      if (n.w1 && hit_alu(n.t1)) begin n.w1 = 0; n.v1 = alu_res_val; end
      else if (n.w1 && hit_lsb(n.t1)) begin n.w1 = 0; n.v1 = lsb_res_val; end
      if (n.w2 && hit_alu(n.t2)) begin n.w2 = 0; n.v2 = alu_res_val; end
      else if (n.w2 && hit_lsb(n.t2)) begin n.w2 = 0; n.v2 = lsb_res_val; end
      m[slot] = n;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] c_v1, c_v2, c_imm, c_pc, c_rob, c_opf;
    int any_en;

    vecs[0] = '{7'h13, 3'd0, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd3, 32'h1000, 4'd2,
                0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd5, 32'd0, 2};
    vecs[1] = '{7'h33, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd7, 32'd0, 32'h1004, 4'd3,
                0, 4'd0, 32'd0, 2, 3, 4'd7, 32'h10, 32'd1, 32'h10, 5};
    vecs[2] = '{7'h33, 3'd4, 1'b0, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0, 32'd0, 32'h1008, 4'd4,
                1, 4'd4, 32'd9, 0, 0, 4'd0, 32'd0, 32'd9, 32'd2, 2};
    vecs[3] = '{7'h33, 3'd7, 1'b0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0, 32'd0, 32'h100c, 4'd5,
                3, 4'd6, 32'hAA, 0, 0, 4'd0, 32'd0, 32'hAA, 32'd3, 2};
    vecs[4] = '{7'h33, 3'd0, 1'b1, 1'b0, 32'd0, 4'd3, 1'b1, 32'h10, 4'd0, 32'd0, 32'h1010, 4'd6,
                0, 4'd0, 32'd0, 1, 1, 4'd3, 32'h1234, 32'h1234, 32'h10, 3};
    vecs[5] = '{7'h37, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'h12345000, 32'h1014, 4'd7,
                1, 4'd5, 32'h77, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 2};
    vecs[6] = '{7'h67, 3'd0, 1'b0, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, 4'd0, 32'd8, 32'h1018, 4'd8,
                1, 4'hE, 32'h99, 2, 2, 4'hF, 32'hDEAD, 32'hDEAD, 32'd0, 4};
    vecs[7] = '{7'h63, 3'd1, 1'b0, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 4'd0, 32'hFFFFFFF0, 32'h101c, 4'd9,
                0, 4'd0, 32'd0, 1, 1, 4'd0, 32'd7, 32'd7, 32'd7, 3};

    // reset state
    do_reset();
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_rs_full", {31'd0, rs_full}, 32'd0);
    chk("rst_alu_val1", alu_val1, 32'd0);
    chk("rst_alu_pc", alu_pc, 32'd0);
    chk("rst_alu_rob", {28'd0, alu_rob_pos}, 32'd0);

    // directed single-op vectors
    foreach (vecs[k]) begin
      do_reset();
      disp(vecs[k].op, vecs[k].r1, vecs[k].v1, vecs[k].t1, vecs[k].r2, vecs[k].v2, vecs[k].t2,
           vecs[k].imm, vecs[k].pc, vecs[k].rob);
      disp_func3 = vecs[k].f3; disp_func1 = vecs[k].f1;
      bcast(vecs[k].bsrc, vecs[k].btag, vecs[k].bval);
      lat = 0;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
        step();
        idle();
        if (vecs[k].wsrc != 0 && c == vecs[k].wcyc) bcast(vecs[k].wsrc, vecs[k].wtag, vecs[k].wval);
        if (alu_en) begin
          lat = c;
          c_v1 = alu_val1; c_v2 = alu_val2; c_imm = alu_imm; c_pc = alu_pc;
          c_rob = {28'd0, alu_rob_pos}; c_opf = {21'd0, alu_opcode, alu_func3, alu_func1};
        end
      end
      if (lat == 0) begin
        chk($sformatf("v%0d_issued", k), 32'd0, 32'd1);
      end else begin
        chk($sformatf("v%0d_latency", k), lat, vecs[k].lat);
        chk($sformatf("v%0d_val1", k), c_v1, vecs[k].e1);
        chk($sformatf("v%0d_val2", k), c_v2, vecs[k].e2);
        chk($sformatf("v%0d_imm", k), c_imm, vecs[k].imm);
        chk($sformatf("v%0d_pc", k), c_pc, vecs[k].pc);
        chk($sformatf("v%0d_rob", k), c_rob, {28'd0, vecs[k].rob});
        chk($sformatf("v%0d_opf", k), c_opf, {21'd0, vecs[k].op, vecs[k].f3, vecs[k].f1});
        step();
        chk($sformatf("v%0d_en_one_cycle", k), {31'd0, alu_en}, 32'd0);
      end
    end

    // fill all entries waiting on tag 1, overflow dispatch, then in-order drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(7'h33, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 32'd0, 32'd100 + i, 4'(i));
      step();
    end
    idle();
    chk("fill_full", {31'd0, rs_full}, 32'd1);
    disp(7'h13, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'd999, 4'd0);
    step();
    idle();
    chk("fill_overflow_full", {31'd0, rs_full}, 32'd1);
    chk("fill_no_issue", {31'd0, alu_en}, 32'd0);
    bcast(1, 4'd1, 32'h55);
    step();
    idle();
    chk("fill_full_after_wake", {31'd0, rs_full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain%0d_en", i), {31'd0, alu_en}, 32'd1);
      chk($sformatf("drain%0d_pc", i), alu_pc, 32'd100 + i);
      chk($sformatf("drain%0d_val1", i), alu_val1, 32'h55);
      if (i == 0) chk("drain_full_drops", {31'd0, rs_full}, 32'd0);
    end
    step();
    chk("drain_overflow_absent", {31'd0, alu_en}, 32'd0);

    // rollback with a ready entry and a concurrent dispatch
    do_reset();
    disp(7'h13, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h200, 4'd1);
    step();
    idle();
    rollback = 1'b1;
    disp(7'h13, 1'b1, 32'd2, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h300, 4'd2);
    step();
    idle();
    chk("rb_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rb_rs_full", {31'd0, rs_full}, 32'd0);
    any_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (alu_en) any_en++;
    end
    chk("rb_never_issues", any_en, 0);

    // rdy low: state frozen, broadcast and dispatch lost
    do_reset();
    disp(7'h33, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 32'd0, 32'h400, 4'd3);
    step();
    disp(7'h13, 1'b1, 32'h11, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h500, 4'd4);
    step();
    idle();
    rdy = 1'b0;
    bcast(1, 4'd9, 32'h77);
    disp(7'h13, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'h600, 4'd5);
    any_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (alu_en) any_en++;
    end
    chk("rdy0_no_issue", any_en, 0);
    idle();
    step();
    chk("rdy1_issue_en", {31'd0, alu_en}, 32'd1);
    chk("rdy1_issue_pc", alu_pc, 32'h500);
    any_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (alu_en) any_en++;
    end
    chk("rdy0_bcast_lost", any_en, 0);
    bcast(2, 4'd9, 32'h88);
    step();
    idle();
    step();
    chk("rdy_late_wake_en", {31'd0, alu_en}, 32'd1);
    chk("rdy_late_wake_pc", alu_pc, 32'h400);
    chk("rdy_late_wake_val1", alu_val1, 32'h88);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) m[i] = '{default: '0};
    exp_en = 0;
    eo = '{default: '0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 99) == 0);
      disp_en = ($urandom_range(0, 9) < 6);
      disp_opcode = 7'($urandom); disp_func3 = 3'($urandom); disp_func1 = 1'($urandom);
      disp_rs1_rdy = 1'($urandom); disp_rs1_val = $urandom; disp_rs1_tag = 4'($urandom_range(0, 7));
      disp_rs2_rdy = 1'($urandom); disp_rs2_val = $urandom; disp_rs2_tag = 4'($urandom_range(0, 7));
      disp_imm = $urandom; disp_pc = $urandom; disp_rob_pos = 4'($urandom);
      alu_res_en = ($urandom_range(0, 9) < 4); alu_res_rob_pos = 4'($urandom_range(0, 7));
      alu_res_val = $urandom;
      lsb_res_en = ($urandom_range(0, 9) < 4); lsb_res_rob_pos = 4'($urandom_range(0, 7));
      lsb_res_val = $urandom;
      chk("rnd_rs_full", {31'd0, rs_full}, {31'd0, model_full()});
      model_step();
      step();
      chk("rnd_alu_en", {31'd0, alu_en}, {31'd0, exp_en});
      chk("rnd_val1", alu_val1, eo.v1);
      chk("rnd_val2", alu_val2, eo.v2);
      chk("rnd_imm", alu_imm, eo.imm);
      chk("rnd_pc", alu_pc, eo.pc);
      chk("rnd_rob_opf", {17'd0, alu_rob_pos, alu_opcode, alu_func3, alu_func1},
          {17'd0, eo.rob, eo.op, eo.f3, eo.f1});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
